// File: rtl/so_arb_pkg.sv
// -----------------------------------------------------------------------------
// so_arb_pkg
// Shared types and helpers for the serializer round-robin scheduler.
//   so_state_e   : scheduler FSM states (IDLE, LOAD, SHIFT, PAR, DONE)
//   SO_WIDTH_DEF : default serial word width
//   SO_NREQ_DEF  : default number of requesters
//   clog2_min1() : ceil(log2(value)), never less than 1 (safe port width)
//   even_parity(): even parity bit of a word (zero-extended to 64 bits)
// -----------------------------------------------------------------------------
package so_arb_pkg;

  localparam int SO_WIDTH_DEF = 16;
  localparam int SO_NREQ_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_PAR   = 3'd3,
    ST_DONE  = 3'd4
  } so_state_e;

  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Parity bit that makes the total number of ones (word + bit) even.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/so_arbiter_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping from N_REQ-1 back to 0.
// Ports:
//   req_i     [N_REQ]  request levels
//   ptr_i     [IDX_W]  highest-priority requester index (0..N_REQ-1)
//   gnt_oh_o  [N_REQ]  one-hot pick (all zero when no request)
//   gnt_idx_o [IDX_W]  index of the pick (0 when no request)
//   any_o              at least one request present
// -----------------------------------------------------------------------------
module rr_arb
  import so_arb_pkg::*;
#(
  parameter int N_REQ = SO_NREQ_DEF,
  parameter int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap correction.
  logic [IDX_W:0] cand_s;
  logic [IDX_W:0] sum_s;

  // Scan requesters in rotation order starting at the pointer; first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand_s    = '0;
    sum_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s  = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      cand_s = (sum_s >= (IDX_W + 1)'(N_REQ)) ? (sum_s - (IDX_W + 1)'(N_REQ)) : sum_s;
      if (!any_o && req_i[cand_s[IDX_W-1:0]]) begin
        any_o                        = 1'b1;
        gnt_idx_o                    = cand_s[IDX_W-1:0];
        gnt_oh_o[cand_s[IDX_W-1:0]]  = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/so_arbiter.sv
// -----------------------------------------------------------------------------
// so_arbiter
// Round-robin scheduler sharing one parallel-in/serial-out serializer among
// N_REQ requesters. A granted word is loaded with a one-cycle so_start pulse,
// the WIDTH-cycle shift window is timed, then the requester gets a one-cycle ack.
// Frame: LOAD(1) + SHIFT(WIDTH) + [PAR(1)] + DONE(1), then at least one IDLE.
// Optional build macro: SO_ARB_PARITY_EN adds a PAR cycle carrying the even
// parity of the word on par_bit; ack moves one cycle later.
// Ports:
//   clk, rst_n              rising-edge clock, async active-low reset
//   req      [N_REQ]        level requests (word held until ack)
//   din_flat [N_REQ*WIDTH]  requester words, requester i at [i*WIDTH +: WIDTH]
//   ack      [N_REQ]        one-cycle pulse when requester i's frame is out
//   busy                    high from LOAD through DONE
//   grant_id                requester being served (valid while busy)
//   so_start                serializer load pulse
//   so_din   [WIDTH]        serializer word, held for the whole frame
//   frame_valid             high during the WIDTH shift cycles
//   bit_cnt                 bit index in frame, 0 = MSB
//   par_bit                 parity cycle output (SO_ARB_PARITY_EN only)
// -----------------------------------------------------------------------------
module so_arbiter
  import so_arb_pkg::*;
#(
  parameter int N_REQ = SO_NREQ_DEF,
  parameter int WIDTH = SO_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*WIDTH-1:0]        din_flat,
  output logic [N_REQ-1:0]              ack,
  output logic                          busy,
  output logic [clog2_min1(N_REQ)-1:0]  grant_id,
  output logic                          so_start,
  output logic [WIDTH-1:0]              so_din,
  output logic                          frame_valid,
  output logic [clog2_min1(WIDTH)-1:0]  bit_cnt
`ifdef SO_ARB_PARITY_EN
  ,
  output logic                          par_bit
`endif
);

  localparam int IDX_W = clog2_min1(N_REQ);
  localparam int CNT_W = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(N_REQ - 1);

  so_state_e          state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [N_REQ-1:0]   gnt_oh_q;
  logic [N_REQ-1:0]   ack_q;
  logic               busy_q;
  logic               start_q;
  logic [WIDTH-1:0]   din_q;
  logic               fv_q;
  logic [CNT_W-1:0]   cnt_q;
`ifdef SO_ARB_PARITY_EN
  logic               par_calc_q;
  logic               par_out_q;
`endif

  logic [N_REQ-1:0]   pick_oh_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;

  rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh_s),
    .gnt_idx_o (pick_idx_s),
    .any_o     (pick_any_s)
  );

  // Scheduler FSM; every output is a register updated on the state transition
  // so it is valid for the whole cycle of the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      gnt_oh_q   <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      din_q      <= '0;
      fv_q       <= 1'b0;
      cnt_q      <= '0;
`ifdef SO_ARB_PARITY_EN
      par_calc_q <= 1'b0;
      par_out_q  <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses default low.
      start_q <= 1'b0;
      ack_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any_s) begin
            state_q  <= ST_LOAD;
            grant_q  <= pick_idx_s;
            gnt_oh_q <= pick_oh_s;
            din_q    <= din_flat[int'(pick_idx_s) * WIDTH +: WIDTH];
            busy_q   <= 1'b1;
            start_q  <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_q <= ST_SHIFT;
          fv_q    <= 1'b1;
          cnt_q   <= '0;
`ifdef SO_ARB_PARITY_EN
          par_calc_q <= even_parity(64'(din_q));
`endif
        end
        ST_SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            fv_q  <= 1'b0;
            cnt_q <= '0;
`ifdef SO_ARB_PARITY_EN
            state_q   <= ST_PAR;
            par_out_q <= par_calc_q;
`else
            state_q   <= ST_DONE;
            ack_q     <= gnt_oh_q;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef SO_ARB_PARITY_EN
        ST_PAR: begin
          state_q   <= ST_DONE;
          par_out_q <= 1'b0;
          ack_q     <= gnt_oh_q;
        end
`endif
        ST_DONE: begin
          // Served requester drops to lowest priority for the next pick.
          state_q  <= ST_IDLE;
          ptr_q    <= (grant_q == LAST_REQ) ? '0 : (grant_q + IDX_W'(1));
          busy_q   <= 1'b0;
          grant_q  <= '0;
          gnt_oh_q <= '0;
          din_q    <= '0;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          fv_q     <= 1'b0;
          cnt_q    <= '0;
          grant_q  <= '0;
          gnt_oh_q <= '0;
          din_q    <= '0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign so_start    = start_q;
  assign so_din      = din_q;
  assign frame_valid = fv_q;
  assign bit_cnt     = cnt_q;
`ifdef SO_ARB_PARITY_EN
  assign par_bit     = par_out_q;
`endif

endmodule

// File: tb/tb_so_arbiter.sv
// -----------------------------------------------------------------------------
// tb_so_arbiter
// Self-checking bench for so_arbiter. A frame-timeline reference model (frame
// position counter plus rotation pointer) predicts every output each cycle.
// Build with SO_ARB_PARITY_EN defined to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_so_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int CW = 4;
`ifdef SO_ARB_PARITY_EN
  localparam int FL     = W + 3;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FL     = W + 2;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int OW = 1 + 1 + 1 + CW + N + IW + W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din_flat;
  logic [N-1:0]     ack;
  logic             busy;
  logic [IW-1:0]    grant_id;
  logic             so_start;
  logic [W-1:0]     so_din;
  logic             frame_valid;
  logic [CW-1:0]    bit_cnt;
  logic             par_bit_s;
  logic [OW-1:0]    obs_s;

  int checks = 0;
  int fails  = 0;

  // reference model state
  bit         m_active;
  int         m_pos;
  int         m_grant;
  int         m_ptr;
  logic [W-1:0] m_word;

  always #5 clk = ~clk;

  so_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .din_flat    (din_flat),
    .ack         (ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .so_start    (so_start),
    .so_din      (so_din),
    .frame_valid (frame_valid),
    .bit_cnt     (bit_cnt)
`ifdef SO_ARB_PARITY_EN
    ,
    .par_bit     (par_bit_s)
`endif
  );
`ifndef SO_ARB_PARITY_EN
  assign par_bit_s = 1'b0;
`endif

  assign obs_s = {busy, so_start, frame_valid, bit_cnt, ack, grant_id, so_din, par_bit_s};

  function automatic void model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_grant  = 0;
    m_ptr    = 0;
    m_word   = '0;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  function automatic void model_edge();
    int idx;
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!m_active && req[idx]) begin
          m_active = 1'b1;
          m_pos    = 0;
          m_grant  = idx;
          m_word   = din_flat[idx*W +: W];
        end
      end
    end else if (m_pos == FL - 1) begin
      m_active = 1'b0;
      m_ptr    = (m_grant + 1) % N;
    end else begin
      m_pos = m_pos + 1;
    end
  endfunction

  // Expected outputs from the frame position: 0 = load, 1..W = bits, last = ack.
  function automatic logic [OW-1:0] model_out();
    logic b, s, fv, p;
    logic [CW-1:0] bc;
    logic [N-1:0]  a;
    logic [IW-1:0] g;
    logic [W-1:0]  wd;
    b  = m_active;
    s  = m_active && (m_pos == 0);
    fv = m_active && (m_pos >= 1) && (m_pos <= W);
    bc = fv ? CW'(m_pos - 1) : '0;
    a  = (m_active && (m_pos == FL - 1)) ? (N'(1) << m_grant) : '0;
    g  = m_active ? IW'(m_grant) : '0;
    wd = m_active ? m_word : '0;
    p  = PAR_EN && m_active && (m_pos == W + 1) && (^m_word);
    return {b, s, fv, bc, a, g, wd, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    din_flat = '0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = '0; din_flat = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_s !== model_out()) begin
      fails++; $display("FAIL reset_async: got %h expected %h", obs_s, model_out());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL reset_hold: got %h expected %h", obs_s, model_out());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] word;
    int start_e, ack_e, fv_cnt, par_e;
    logic [W-1:0] ld_word;
    do_reset();
    word = PAR_EN ? 16'h0007 : 16'hA5C3;
    din_flat[0 +: W] = word;
    req = 4'b0001;
    start_e = -1; ack_e = -1; fv_cnt = 0; par_e = -1; ld_word = '0;
    for (int e = 0; e < FL + 4; e++) begin
      tick();
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL single_cycle: edge %0d got %h expected %h", e, obs_s, model_out());
      end
      if (so_start && start_e < 0) begin start_e = e; ld_word = so_din; end
      if (frame_valid) fv_cnt++;
      if (par_bit_s && par_e < 0) par_e = e;
      if (ack[0] && ack_e < 0) begin ack_e = e; req = 4'b0000; end
    end
    checks++;
    if (start_e !== 0) begin fails++; $display("FAIL single_start: got edge %0d expected 0", start_e); end
    checks++;
    if (ld_word !== word) begin fails++; $display("FAIL single_din: got %h expected %h", ld_word, word); end
    checks++;
    if (fv_cnt !== 16) begin fails++; $display("FAIL single_fv_len: got %0d expected 16", fv_cnt); end
    checks++;
    if (ack_e !== (PAR_EN ? 18 : 17)) begin
      fails++; $display("FAIL single_ack_time: got edge %0d expected %0d", ack_e, PAR_EN ? 18 : 17);
    end
`ifdef SO_ARB_PARITY_EN
    checks++;
    if (par_e !== 17) begin fails++; $display("FAIL parity_bit: seen at edge %0d expected 17", par_e); end
`endif
  endtask

  task automatic test_rotation();
    int grants[$];
    int acks;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] words[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_reset();
    for (int i = 0; i < N; i++) din_flat[i*W +: W] = words[i];
    req = 4'b1111;
    acks = 0;
    for (int e = 0; e < 6 * (FL + 1) && acks < 5; e++) begin
      tick();
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL rot_cycle: edge %0d got %h expected %h", e, obs_s, model_out());
      end
      if (so_start) begin
        grants.push_back(int'(grant_id));
        checks++;
        if (so_din !== words[grant_id]) begin
          fails++; $display("FAIL rot_word: got %h expected %h", so_din, words[grant_id]);
        end
      end
      if (ack != '0) acks++;
    end
    req = '0;
    checks++;
    if (acks !== 5) begin fails++; $display("FAIL rot_acks: got %0d expected 5", acks); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= grants.size() || grants[i] !== exp_g[i]) begin
        fails++; $display("FAIL rot_order: slot %0d got %0d expected %0d", i,
                          (i < grants.size()) ? grants[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int grants[$];
    int acks;
    int exp_g[3] = '{2, 0, 2};
    do_reset();
    din_flat = {16'hD004, 16'hC003, 16'hB002, 16'hA001};
    req = 4'b0100;
    acks = 0;
    for (int e = 0; e < 4 * (FL + 1) && acks < 3; e++) begin
      tick();
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL wrap_cycle: edge %0d got %h expected %h", e, obs_s, model_out());
      end
      if (so_start) grants.push_back(int'(grant_id));
      if (ack != '0) begin
        acks++;
        if (acks == 1) req = 4'b0101;
      end
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= grants.size() || grants[i] !== exp_g[i]) begin
        fails++; $display("FAIL wrap_order: slot %0d got %0d expected %0d", i,
                          (i < grants.size()) ? grants[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_req_drop();
    bit ack_seen;
    int restarts, max_bit;
    do_reset();
    din_flat[1*W +: W] = 16'h5A5A;
    req = 4'b0010;
    ack_seen = 1'b0; restarts = 0; max_bit = -1;
    for (int e = 0; e < FL + 8; e++) begin
      tick();
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL drop_cycle: edge %0d got %h expected %h", e, obs_s, model_out());
      end
      if (frame_valid && bit_cnt == 4'd5) req = 4'b0000;
      if (frame_valid && int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
      if (ack[1]) ack_seen = 1'b1;
      if (so_start && e > 0) restarts++;
    end
    checks++;
    if (!ack_seen) begin fails++; $display("FAIL drop_ack: got 0 expected 1"); end
    checks++;
    if (max_bit !== 15) begin fails++; $display("FAIL drop_last_bit: got %0d expected 15", max_bit); end
    checks++;
    if (restarts !== 0) begin fails++; $display("FAIL drop_restart: got %0d expected 0", restarts); end
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    int acks, first_g;
    do_reset();
    din_flat = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
    req = 4'b0010;
    hit = 1'b0; acks = 0;
    for (int e = 0; e < FL && !hit; e++) begin
      tick();
      if (ack != '0) acks++;
      if (frame_valid && bit_cnt == 4'd8) hit = 1'b1;
    end
    checks++;
    if (!hit) begin fails++; $display("FAIL rstmid_reach: bit 8 not reached"); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (so_start !== 1'b0 || frame_valid !== 1'b0 || ack !== '0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_drop: got start=%b fv=%b ack=%b busy=%b expected all 0",
                        so_start, frame_valid, ack, busy);
    end
    req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ack != '0) acks++;
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL rstmid_hold: got %h expected %h", obs_s, model_out());
      end
    end
    rst_n = 1'b1;
    first_g = -1;
    for (int e = 0; e < 4 && first_g < 0; e++) begin
      tick();
      if (ack != '0) acks++;
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL rstmid_resume: got %h expected %h", obs_s, model_out());
      end
      if (so_start) first_g = int'(grant_id);
    end
    checks++;
    if (first_g !== 0) begin fails++; $display("FAIL rstmid_first: got grant %0d expected 0", first_g); end
    checks++;
    if (acks !== 0) begin fails++; $display("FAIL rstmid_noack: got %0d acks expected 0", acks); end
    req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    int waits[N];
    int a_idx;
    do_reset();
    pending = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int e = 0; e < 800; e++) begin
      din_flat = {$urandom, $urandom};
      tick();
      checks++;
      if (obs_s !== model_out()) begin
        fails++; $display("FAIL rand_cycle: edge %0d got %h expected %h", e, obs_s, model_out());
      end
      if (ack != '0) begin
        a_idx = -1;
        for (int i = 0; i < N; i++) if (ack[i]) a_idx = i;
        for (int i = 0; i < N; i++) begin
          if (i == a_idx) begin
            waits[i] = 0;
          end else if (pending[i]) begin
            waits[i]++;
            checks++;
            if (waits[i] > N - 1) begin
              fails++; $display("FAIL rand_starve: req %0d waited %0d frames expected <= %0d", i, waits[i], N - 1);
            end
          end
        end
        if (a_idx >= 0) pending[a_idx] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(3, 0) == 0)) pending[i] = 1'b1;
      end
      req = pending;
    end
    req = '0;
  endtask

  initial begin
    #(200_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_rotation();
    test_wrap();
    test_req_drop();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
